// File: rtl/wbuf_rd_arbiter.sv
// wbuf_rd_arbiter: shares the single weight-buffer read port between the four
// per-mode weight address generators (0 CONV, 1 FC, 2 ADD, 3 POOL).
// While a layer runs, the generator picked by the decoded mode owns the port
// (LOCKED). Outside a layer, requests are served round-robin. Read data is
// steered back to its requester by a grant tag delayed by RD_LAT cycles.
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   start_calculate   layer start pulse; mode selects the owner (1..4)
//   mode              decoded mode: 1 CONV, 2 FC, 3 ADD, 4 POOL
//   layer_done        layer completion pulse
//   req_rd_en         per-requester read request
//   req_addr          per-requester address, requester i at [i*ADDR_W +: ADDR_W]
//   req_gnt           one-hot grant, combinational
//   wb_rd_en, wb_addr weight buffer read port (combinational mux)
//   wb_rdata          weight buffer read data, RD_LAT cycles after wb_rd_en
//   rsp_valid         one-hot owner of rsp_data
//   rsp_data          wb_rdata passed through
//   busy              high in LOCKED or DRAIN
//   owner             locked requester index, 0 when IDLE
//   err_start         sticky: start seen in a non-IDLE state or with bad mode
module wbuf_rd_arbiter #(
    parameter int unsigned ADDR_W = 13,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned RD_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_calculate,
    input  logic [3:0]            mode,
    input  logic                  layer_done,
    input  logic [3:0]            req_rd_en,
    input  logic [4*ADDR_W-1:0]   req_addr,
    output logic [3:0]            req_gnt,
    output logic                  wb_rd_en,
    output logic [ADDR_W-1:0]     wb_addr,
    input  logic [DATA_W-1:0]     wb_rdata,
    output logic [3:0]            rsp_valid,
    output logic [DATA_W-1:0]     rsp_data,
    output logic                  busy,
    output logic [1:0]            owner,
    output logic                  err_start
);

    localparam int unsigned N_REQ = 4;
    localparam int unsigned CNT_W = 2;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOCKED = 2'd1,
        S_DRAIN  = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [1:0]              r_rr_ptr,  w_rr_nxt;
    logic [1:0]              r_owner,   w_owner_nxt;
    logic                    r_err,     w_err_nxt;
    logic [CNT_W-1:0]        r_cnt,     w_cnt_nxt;
    logic [ADDR_W-1:0]       r_last_addr;
    logic [RD_LAT-1:0][3:0]  r_tag;

    logic [N_REQ-1:0]        w_gnt;
    logic [N_REQ-1:0]        w_rr_gnt;
    logic [1:0]              w_rr_idx;
    logic                    w_rr_hit;
    logic                    w_mode_ok;
    logic [ADDR_W-1:0]       w_addr;

    assign w_mode_ok = (mode >= 4'd1) && (mode <= 4'd4);

    // Round-robin search starting at r_rr_ptr; 2-bit index arithmetic wraps.
    always_comb begin
        w_rr_hit = 1'b0;
        w_rr_idx = r_rr_ptr;
        w_rr_gnt = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!w_rr_hit && req_rd_en[r_rr_ptr + 2'(i)]) begin
                w_rr_hit = 1'b1;
                w_rr_idx = r_rr_ptr + 2'(i);
            end
        end
        w_rr_gnt[w_rr_idx] = w_rr_hit;
    end

    // State register and the registers steered by the FSM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_rr_ptr <= '0;
            r_owner  <= '0;
            r_err    <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_rr_ptr <= w_rr_nxt;
            r_owner  <= w_owner_nxt;
            r_err    <= w_err_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

    // Next-state and grant logic.
    always_comb begin
        w_state_nxt = r_state;
        w_rr_nxt    = r_rr_ptr;
        w_owner_nxt = r_owner;
        w_err_nxt   = r_err;
        w_cnt_nxt   = r_cnt;
        w_gnt       = '0;
        case (r_state)
            S_IDLE: begin
                // A start cycle never grants, legal mode or not.
                if (start_calculate) begin
                    if (w_mode_ok) begin
                        w_state_nxt = S_LOCKED;
                        w_owner_nxt = 2'(mode - 4'd1);
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end else begin
                    w_gnt = w_rr_gnt;
                    if (w_rr_hit) begin
                        w_rr_nxt = w_rr_idx + 2'd1;
                    end
                end
            end
            S_LOCKED: begin
                w_gnt[r_owner] = req_rd_en[r_owner];
                if (start_calculate) begin
                    w_err_nxt = 1'b1;
                end
                if (layer_done) begin
                    w_state_nxt = S_DRAIN;
                    w_cnt_nxt   = CNT_W'(RD_LAT - 1);
                end
            end
            S_DRAIN: begin
                if (start_calculate) begin
                    w_err_nxt = 1'b1;
                end
                if (r_cnt == '0) begin
                    w_state_nxt = S_IDLE;
                    w_owner_nxt = '0;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_owner_nxt = '0;
            end
        endcase
    end

    // Grants are forced low while reset is asserted.
    assign req_gnt  = w_gnt & {N_REQ{rst}};
    assign wb_rd_en = |req_gnt;

    // Address mux; holds the last granted address when nothing is granted.
    always_comb begin
        w_addr = r_last_addr;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (req_gnt[i]) begin
                w_addr = req_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    assign wb_addr = w_addr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_addr <= '0;
        end else begin
            r_last_addr <= w_addr;
        end
    end

    // Grant tag pipeline, RD_LAT deep, aligned with wb_rdata.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tag <= '0;
        end else begin
            r_tag[0] <= req_gnt;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    assign rsp_valid = r_tag[RD_LAT-1];
    assign rsp_data  = wb_rdata;
    assign busy      = (r_state != S_IDLE);
    assign owner     = r_owner;
    assign err_start = r_err;

endmodule

// File: tb/tb_wbuf_rd_arbiter.sv
// Self-checking bench for wbuf_rd_arbiter (RD_LAT = 2): a table of per-cycle
// vectors followed by a hand-written reset-during-LOCKED sequence.
module tb_wbuf_rd_arbiter;

    localparam int unsigned ADDR_W = 13;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned RD_LAT = 2;
    localparam int unsigned N_VEC  = 27;

    logic                 clk;
    logic                 rst;
    logic                 start_calculate;
    logic [3:0]           mode;
    logic                 layer_done;
    logic [3:0]           req_rd_en;
    logic [4*ADDR_W-1:0]  req_addr;
    logic [3:0]           req_gnt;
    logic                 wb_rd_en;
    logic [ADDR_W-1:0]    wb_addr;
    logic [DATA_W-1:0]    wb_rdata;
    logic [3:0]           rsp_valid;
    logic [DATA_W-1:0]    rsp_data;
    logic                 busy;
    logic [1:0]           owner;
    logic                 err_start;

    int n_checks;
    int n_fail;

    wbuf_rd_arbiter #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .RD_LAT(RD_LAT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start_calculate(start_calculate),
        .mode           (mode),
        .layer_done     (layer_done),
        .req_rd_en      (req_rd_en),
        .req_addr       (req_addr),
        .req_gnt        (req_gnt),
        .wb_rd_en       (wb_rd_en),
        .wb_addr        (wb_addr),
        .wb_rdata       (wb_rdata),
        .rsp_valid      (rsp_valid),
        .rsp_data       (rsp_data),
        .busy           (busy),
        .owner          (owner),
        .err_start      (err_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic [3:0]  md;
        logic        dn;
        logic [3:0]  rq;
        logic [12:0] a2;
        logic [3:0]  gnt;
        logic [12:0] addr;
        logic [3:0]  rsp;
        logic        bsy;
        logic [1:0]  own;
        logic        err;
    } vec_t;

    vec_t tv [N_VEC];

    function automatic vec_t v(input logic st, input logic [3:0] md, input logic dn,
                               input logic [3:0] rq, input logic [12:0] a2,
                               input logic [3:0] gnt, input logic [12:0] addr,
                               input logic [3:0] rsp, input logic bsy,
                               input logic [1:0] own, input logic err);
        vec_t r;
        r.st = st; r.md = md; r.dn = dn; r.rq = rq; r.a2 = a2;
        r.gnt = gnt; r.addr = addr; r.rsp = rsp; r.bsy = bsy; r.own = own; r.err = err;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Requesters 0, 1, 3 have fixed addresses; requester 2 (ADD) is per vector.
    task automatic drive(input logic st, input logic [3:0] md, input logic dn,
                         input logic [3:0] rq, input logic [12:0] a2);
        start_calculate = st;
        mode            = md;
        layer_done      = dn;
        req_rd_en       = rq;
        req_addr        = {13'h013, a2, 13'h011, 13'h010};
    endtask

    task automatic chk_idle_zero(input string tag);
        chk($sformatf("%s.gnt", tag),   64'(req_gnt),   64'h0);
        chk($sformatf("%s.rd_en", tag), 64'(wb_rd_en),  64'h0);
        chk($sformatf("%s.addr", tag),  64'(wb_addr),   64'h0);
        chk($sformatf("%s.rsp", tag),   64'(rsp_valid), 64'h0);
        chk($sformatf("%s.busy", tag),  64'(busy),      64'h0);
        chk($sformatf("%s.owner", tag), 64'(owner),     64'h0);
        chk($sformatf("%s.err", tag),   64'(err_start), 64'h0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b0;
        wb_rdata = '0;
        drive(1'b0, 4'd0, 1'b0, 4'h0, 13'h012);

        //           st md dn rq   a2       gnt  addr     rsp  bsy own err
        tv[0]  = v(0, 0, 0, 4'h0, 13'h012, 4'h0, 13'h000, 4'h0, 0, 0, 0);
        tv[1]  = v(0, 0, 0, 4'hF, 13'h012, 4'h1, 13'h010, 4'h0, 0, 0, 0);
        tv[2]  = v(0, 0, 0, 4'hF, 13'h012, 4'h2, 13'h011, 4'h0, 0, 0, 0);
        tv[3]  = v(0, 0, 0, 4'hF, 13'h012, 4'h4, 13'h012, 4'h1, 0, 0, 0);
        tv[4]  = v(0, 0, 0, 4'hF, 13'h012, 4'h8, 13'h013, 4'h2, 0, 0, 0);
        tv[5]  = v(0, 0, 0, 4'hF, 13'h012, 4'h1, 13'h010, 4'h4, 0, 0, 0);
        tv[6]  = v(0, 0, 0, 4'h0, 13'h012, 4'h0, 13'h010, 4'h8, 0, 0, 0);
        tv[7]  = v(0, 0, 0, 4'h2, 13'h012, 4'h2, 13'h011, 4'h1, 0, 0, 0);
        tv[8]  = v(0, 0, 0, 4'hA, 13'h012, 4'h8, 13'h013, 4'h0, 0, 0, 0);
        tv[9]  = v(0, 0, 0, 4'hA, 13'h012, 4'h2, 13'h011, 4'h2, 0, 0, 0);
        tv[10] = v(0, 0, 0, 4'hA, 13'h012, 4'h8, 13'h013, 4'h8, 0, 0, 0);
        tv[11] = v(1, 0, 0, 4'hA, 13'h012, 4'h0, 13'h013, 4'h2, 0, 0, 0);
        tv[12] = v(1, 3, 0, 4'h0, 13'h012, 4'h0, 13'h013, 4'h8, 0, 0, 1);
        tv[13] = v(0, 0, 0, 4'h5, 13'h100, 4'h4, 13'h100, 4'h0, 1, 2, 1);
        tv[14] = v(0, 0, 0, 4'h1, 13'h100, 4'h0, 13'h100, 4'h0, 1, 2, 1);
        tv[15] = v(0, 0, 0, 4'h5, 13'h101, 4'h4, 13'h101, 4'h4, 1, 2, 1);
        tv[16] = v(1, 1, 0, 4'h1, 13'h101, 4'h0, 13'h101, 4'h0, 1, 2, 1);
        tv[17] = v(0, 0, 1, 4'h5, 13'h102, 4'h4, 13'h102, 4'h4, 1, 2, 1);
        tv[18] = v(0, 0, 0, 4'h5, 13'h102, 4'h0, 13'h102, 4'h0, 1, 2, 1);
        tv[19] = v(0, 0, 0, 4'h0, 13'h102, 4'h0, 13'h102, 4'h4, 1, 2, 1);
        tv[20] = v(0, 0, 0, 4'h0, 13'h102, 4'h0, 13'h102, 4'h0, 0, 0, 1);
        tv[21] = v(1, 2, 1, 4'h0, 13'h102, 4'h0, 13'h102, 4'h0, 0, 0, 1);
        tv[22] = v(0, 0, 0, 4'h0, 13'h102, 4'h0, 13'h102, 4'h0, 1, 1, 1);
        tv[23] = v(0, 0, 1, 4'h0, 13'h102, 4'h0, 13'h102, 4'h0, 1, 1, 1);
        tv[24] = v(0, 0, 0, 4'h0, 13'h102, 4'h0, 13'h102, 4'h0, 1, 1, 1);
        tv[25] = v(0, 0, 0, 4'h0, 13'h102, 4'h0, 13'h102, 4'h0, 1, 1, 1);
        tv[26] = v(0, 0, 0, 4'hF, 13'h012, 4'h1, 13'h010, 4'h0, 0, 0, 1);

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk_idle_zero("reset");
        @(negedge clk);
        rst = 1'b1;

        // Table: inputs applied 1 time unit after the edge, checked 1 unit later.
        for (int i = 0; i < int'(N_VEC); i++) begin
            @(posedge clk);
            #1;
            drive(tv[i].st, tv[i].md, tv[i].dn, tv[i].rq, tv[i].a2);
            wb_rdata = {32'hC0DE0000 + 32'(i), 32'(i) ^ 32'h5A5A5A5A};
            #1;
            chk($sformatf("v%0d.gnt", i),   64'(req_gnt),   64'(tv[i].gnt));
            chk($sformatf("v%0d.rd_en", i), 64'(wb_rd_en),  64'(|tv[i].gnt));
            chk($sformatf("v%0d.addr", i),  64'(wb_addr),   64'(tv[i].addr));
            chk($sformatf("v%0d.rsp", i),   64'(rsp_valid), 64'(tv[i].rsp));
            chk($sformatf("v%0d.busy", i),  64'(busy),      64'(tv[i].bsy));
            chk($sformatf("v%0d.owner", i), 64'(owner),     64'(tv[i].own));
            chk($sformatf("v%0d.err", i),   64'(err_start), 64'(tv[i].err));
            chk($sformatf("v%0d.rdata", i), rsp_data,
                {32'hC0DE0000 + 32'(i), 32'(i) ^ 32'h5A5A5A5A});
        end

        // Reset while LOCKED (owner CONV) with a read in flight.
        @(posedge clk); #1;
        drive(1'b1, 4'd1, 1'b0, 4'h0, 13'h012);
        @(posedge clk); #1;
        drive(1'b0, 4'd0, 1'b0, 4'h1, 13'h012);
        #1;
        chk("mid.gnt",   64'(req_gnt), 64'h1);
        chk("mid.owner", 64'(owner),   64'h0);
        chk("mid.busy",  64'(busy),    64'h1);
        @(posedge clk); #1;
        drive(1'b0, 4'd0, 1'b0, 4'h0, 13'h012);
        #1;
        chk("mid.rsp_pre", 64'(rsp_valid), 64'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk_idle_zero("midrst");
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk($sformatf("post%0d.rsp", k),  64'(rsp_valid), 64'h0);
            chk($sformatf("post%0d.busy", k), 64'(busy),      64'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
